seg_serial_tx: RTL and testbench

- Consumer end of the 8-digit segment-text path: accepts the 64-bit parallel segment image produced by the hex-to-segment encoder (8 digits × {a,b,c,d,e,f,g,p}).
- Shifts the image out MSB-first to the board's serial-in/parallel-out display shift-register chain, then pulses a latch strobe.
- Sits between the display encoder and the top-level display pins; one transfer per start request.

---
 rtl/seg_tx_pkg.sv | 19 +
 rtl/seg_tx_tick.sv | 38 +++
 rtl/seg_serial_tx.sv | 147 ++++++++++++++
 tb/tb_seg_serial_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_tx_pkg.sv
// Shared types and defaults for the segment-image serial transmitter.
package seg_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_DIV   = 2;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_tx_tick.sv
// DIV-cycle terminal-count divider; tick marks the last cycle of each period.
module seg_tx_tick
  import seg_tx_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  assign tick = (div_cnt_q == LAST);

  // Next count: hold at zero while cleared, wrap on terminal count.
  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    if (clr || tick) begin
      div_cnt_d = '0;
    end
  end

  // Divider count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/seg_serial_tx.sv
// Shifts a parallel segment image MSB-first into the display shift chain,
// then strobes the latch. All pin outputs come straight from flops.
module seg_serial_tx
  import seg_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             sout,
  output logic             sclk,
  output logic             slatch,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             phase_q,   phase_d;
  logic             sout_q,    sout_d;
  logic             sclk_q,    sclk_d;
  logic             slatch_q,  slatch_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic tick;
  logic tick_clr;

  // Divider runs only through SHIFT and LATCH; held at zero otherwise.
  assign tick_clr = (state_q == IDLE) || (state_q == DONE);

  seg_tx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    sout_d    = sout_q;
    sclk_d    = sclk_q;
    slatch_d  = slatch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sclk_d   = 1'b0;
        slatch_d = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          shreg_d   = par_data;
          sout_d    = par_data[WIDTH-1];
          bit_cnt_d = '0;
          phase_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            sclk_d   = 1'b0;
            slatch_d = 1'b1;
            state_d  = LATCH;
          end else begin
            // Rotate rather than zero-fill: only the MSB side is ever
            // driven out, so the pin sequence is identical.
            shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            sout_d    = shreg_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q + BW'(1);
            sclk_d    = 1'b0;
            phase_d   = 1'b0;
          end
        end
      end

      LATCH: begin
        sclk_d = 1'b0;
        if (tick) begin
          slatch_d = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sout_q    <= 1'b0;
      sclk_q    <= 1'b0;
      slatch_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      sout_q    <= sout_d;
      sclk_q    <= sclk_d;
      slatch_q  <= slatch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sout   = sout_q;
  assign sclk   = sclk_q;
  assign slatch = slatch_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seg_serial_tx.sv
// Self-checking bench for seg_serial_tx: a 64-bit/DIV=2 instance and an
// 8-bit/DIV=1 instance, checked against cycle formulas for each transfer.
module tb_seg_serial_tx;

  logic        clk;
  logic        rst_n;

  logic        s64;
  logic [63:0] pd64;
  logic        o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done;

  logic        s8;
  logic [7:0]  pd8;
  logic        o8_sout, o8_sclk, o8_slatch, o8_busy, o8_done;

  int checks;
  int errors;

  seg_serial_tx #(
    .WIDTH (64),
    .DIV   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s64),
    .par_data (pd64),
    .sout     (o64_sout),
    .sclk     (o64_sclk),
    .slatch   (o64_slatch),
    .busy     (o64_busy),
    .done     (o64_done)
  );

  seg_serial_tx #(
    .WIDTH (8),
    .DIV   (1)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s8),
    .par_data (pd8),
    .sout     (o8_sout),
    .sclk     (o8_sclk),
    .slatch   (o8_slatch),
    .busy     (o8_busy),
    .done     (o8_done)
  );

  always #5 clk = ~clk;

  // One transfer on the selected instance, compared cycle by cycle with
  // the formula model: cycle k (sampled after edge k, accept = edge 0)
  // carries bit k/(2*DIV), sclk is high in the second half of each bit
  // window, slatch follows for DIV cycles, then a single done cycle.
  task automatic do_transfer(input bit sel8, input logic [63:0] data,
                             input bit disturb, input string name);
    int unsigned w, dv, win, total, rises;
    int unsigned e_so, e_sc, e_sl, e_bz, e_dn;
    logic [63:0] recon, exp_word;
    logic prev_sc, so, sc, sl, bz, dn;
    logic x_so, x_sc, x_sl, x_bz, x_dn;
    w = sel8 ? 8 : 64;
    dv = sel8 ? 1 : 2;
    win = 2 * dv * w;
    total = win + dv + 1;
    rises = 0; recon = '0; prev_sc = 1'b0;
    e_so = 0; e_sc = 0; e_sl = 0; e_bz = 0; e_dn = 0;
    exp_word = sel8 ? {56'd0, data[7:0]} : data;
    if (sel8) begin pd8 = data[7:0]; s8 = 1'b1; end
    else begin pd64 = data; s64 = 1'b1; end
    for (int unsigned k = 0; k < total + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin s8 = 1'b0; s64 = 1'b0; end
      if (disturb && k == 5 * dv) begin
        pd8 = ~pd8; pd64 = {$urandom, $urandom};
        s8 = sel8; s64 = !sel8;
      end
      if (disturb && k == 5 * dv + 1) begin s8 = 1'b0; s64 = 1'b0; end
      so = sel8 ? o8_sout   : o64_sout;
      sc = sel8 ? o8_sclk   : o64_sclk;
      sl = sel8 ? o8_slatch : o64_slatch;
      bz = sel8 ? o8_busy   : o64_busy;
      dn = sel8 ? o8_done   : o64_done;
      x_bz = (k < total);
      x_sc = (k < win) && ((k % (2 * dv)) >= dv);
      x_sl = (k >= win) && (k < win + dv);
      x_dn = (k == win + dv);
      if (k < win) begin
        x_so = data[w - 1 - k / (2 * dv)];
        if (so !== x_so) begin
          if (e_so == 0) $display("FAIL %s sout cycle %0d: got %b want %b", name, k, so, x_so);
          e_so++;
        end
      end
      if (sc !== x_sc) begin
        if (e_sc == 0) $display("FAIL %s sclk cycle %0d: got %b want %b", name, k, sc, x_sc);
        e_sc++;
      end
      if (sl !== x_sl) begin
        if (e_sl == 0) $display("FAIL %s slatch cycle %0d: got %b want %b", name, k, sl, x_sl);
        e_sl++;
      end
      if (bz !== x_bz) begin
        if (e_bz == 0) $display("FAIL %s busy cycle %0d: got %b want %b", name, k, bz, x_bz);
        e_bz++;
      end
      if (dn !== x_dn) begin
        if (e_dn == 0) $display("FAIL %s done cycle %0d: got %b want %b", name, k, dn, x_dn);
        e_dn++;
      end
      if (sc === 1'b1 && prev_sc === 1'b0) begin
        recon = {recon[62:0], so};
        rises++;
      end
      prev_sc = sc;
    end
    checks += 7;
    if (e_so != 0) errors++;
    if (e_sc != 0) errors++;
    if (e_sl != 0) errors++;
    if (e_bz != 0) errors++;
    if (e_dn != 0) errors++;
    if (rises !== w) begin
      $display("FAIL %s rise_count: got %0d want %0d", name, rises, w);
      errors++;
    end
    if (recon !== exp_word) begin
      $display("FAIL %s reconstructed: got %h want %h", name, recon, exp_word);
      errors++;
    end
  endtask

  task automatic test_reset();
    int unsigned bad;
    #1;
    checks++;
    if ({o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done,
         o8_sout, o8_sclk, o8_slatch, o8_busy, o8_done} !== 10'b0) begin
      $display("FAIL reset_outputs: got %b%b%b%b%b want 00000",
               o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done,
           o8_sout, o8_sclk, o8_slatch, o8_busy, o8_done} !== 10'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL idle_quiet: got %0d nonzero cycles want 0", bad);
      errors++;
    end
  endtask

  task automatic test_single();
    do_transfer(1'b0, 64'h8000_0000_0000_0001, 1'b0, "single_edges");
  endtask

  task automatic test_disturb();
    do_transfer(1'b0, 64'hC0F9_A4B0_9992_82F8, 1'b1, "disturb_fixed");
    do_transfer(1'b0, {$urandom, $urandom}, 1'b1, "disturb_random");
    do_transfer(1'b0, {$urandom, $urandom}, 1'b0, "random");
  endtask

  task automatic test_back_to_back();
    int unsigned e_bz, e_dn, n_done, waited;
    e_bz = 0; e_dn = 0; n_done = 0;
    pd64 = {$urandom, $urandom};
    s64 = 1'b1;
    for (int unsigned k = 0; k < 600; k++) begin
      @(negedge clk);
      // 259 busy cycles then one idle cycle, repeating.
      if (o64_busy !== ((k % 260) != 259)) begin
        if (e_bz == 0) $display("FAIL b2b busy cycle %0d: got %b want %b", k, o64_busy, (k % 260) != 259);
        e_bz++;
      end
      if (o64_done !== ((k % 260) == 258)) begin
        if (e_dn == 0) $display("FAIL b2b done cycle %0d: got %b want %b", k, o64_done, (k % 260) == 258);
        e_dn++;
      end
      if (o64_done === 1'b1) n_done++;
    end
    s64 = 1'b0;
    checks += 3;
    if (e_bz != 0) errors++;
    if (e_dn != 0) errors++;
    if (n_done !== 2) begin
      $display("FAIL b2b done_count: got %0d want 2", n_done);
      errors++;
    end
    waited = 0;
    while (o64_busy === 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (o64_busy !== 1'b0) begin
      $display("FAIL b2b drain_timeout: got busy %b want 0", o64_busy);
      errors++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midway();
    int unsigned bad;
    pd64 = {$urandom, $urandom};
    s64 = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k == 0) s64 = 1'b0;
    end
    checks++;
    if (o64_busy !== 1'b1) begin
      $display("FAIL midreset_busy_before: got %b want 1", o64_busy);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done} !== 5'b0) begin
      $display("FAIL midreset_async: got %b%b%b%b%b want 00000",
               o64_sout, o64_sclk, o64_slatch, o64_busy, o64_done);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o64_busy !== 1'b0 || o64_slatch !== 1'b0 || o64_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL midreset_no_resume: got %0d active cycles want 0", bad);
      errors++;
    end
    do_transfer(1'b0, {$urandom, $urandom}, 1'b0, "after_reset");
  endtask

  task automatic test_narrow();
    do_transfer(1'b1, 64'hA5, 1'b0, "w8_a5");
    do_transfer(1'b1, {56'd0, 8'($urandom)}, 1'b1, "w8_random");
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    s64 = 1'b0; pd64 = '0;
    s8 = 1'b0;  pd8 = '0;
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_disturb();
    test_back_to_back();
    test_reset_midway();
    test_narrow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
